// File: rtl/cache_wb_buffer.sv
// cache_wb_buffer
// Single-entry victim/writeback buffer. Captures a whole dirty line from the
// data bank in one cycle so the bank is free again immediately, then drains
// it to memory as a single AXI4 INCR write burst (AW, then W beats, then B).
// While a line is held, query_hit flags a matching line address so the cache
// can hold off a refill of a line that has not yet reached memory.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   push/push_ready          victim load handshake (push_ready = empty & idle)
//   push_addr, push_line     victim byte address and line data (word 0 in LSBs)
//   query_addr/query_hit     line-granular match against the buffered line
//   bus_err                  one-cycle pulse on a non-OKAY write response
//   aw*, w*, b*              AXI4 write address / data / response channels
module cache_wb_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    output logic                           push_ready,
    input  logic [ADDR_WIDTH-1:0]          push_addr,
    input  logic [DATA_WIDTH*LINE_WORDS-1:0] push_line,
    input  logic [ADDR_WIDTH-1:0]          query_addr,
    output logic                           query_hit,
    output logic                           bus_err,
    output logic [ADDR_WIDTH-1:0]          awaddr,
    output logic [7:0]                     awlen,
    output logic [2:0]                     awsize,
    output logic [1:0]                     awburst,
    output logic                           awvalid,
    input  logic                           awready,
    output logic [DATA_WIDTH-1:0]          wdata,
    output logic [DATA_WIDTH/8-1:0]        wstrb,
    output logic                           wlast,
    output logic                           wvalid,
    input  logic                           wready,
    input  logic [1:0]                     bresp,
    input  logic                           bvalid,
    output logic                           bready
);

    localparam int BYTES_W  = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(LINE_WORDS * BYTES_W);
    localparam int CNT_W    = $clog2(LINE_WORDS);
    localparam int SIZE     = $clog2(BYTES_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t                               r_state;
    state_t                               w_next;
    logic [ADDR_WIDTH-OFF_BITS-1:0]       r_tag;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] r_line;
    logic [CNT_W-1:0]                     r_cnt;
    logic                                 w_push_acc;
    logic                                 w_last;

    assign w_push_acc = push && (r_state == S_IDLE);
    assign w_last     = (r_cnt == CNT_W'(LINE_WORDS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Beat counter: restarts on every accepted push, advances per W handshake
    // except the last, so it stays parked on the final word until RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_push_acc) begin
            r_cnt <= '0;
        end else if (r_state == S_DATA && wready && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Line storage needs no reset: it is only observed outside IDLE, and
    // leaving IDLE always loads it.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_tag  <= push_addr[ADDR_WIDTH-1:OFF_BITS];
            r_line <= push_line;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (push)                 w_next = S_ADDR;
            S_ADDR: if (awready)              w_next = S_DATA;
            S_DATA: if (wready && w_last)     w_next = S_RESP;
            S_RESP: if (bvalid)               w_next = S_IDLE;
            default:                          w_next = S_IDLE;
        endcase
    end

    // All channel outputs are decoded from registered state, so they cannot
    // move while a valid is stalled waiting for its ready.
    assign push_ready = (r_state == S_IDLE);
    assign query_hit  = (r_state != S_IDLE) &&
                        (query_addr[ADDR_WIDTH-1:OFF_BITS] == r_tag);
    assign bus_err    = (r_state == S_RESP) && bvalid && (bresp != 2'b00);

    assign awaddr  = {r_tag, {OFF_BITS{1'b0}}};
    assign awlen   = 8'(LINE_WORDS - 1);
    assign awsize  = 3'(SIZE);
    assign awburst = 2'b01;
    assign awvalid = (r_state == S_ADDR);

    assign wdata  = r_line[r_cnt];
    assign wstrb  = '1;
    assign wlast  = (r_state == S_DATA) && w_last;
    assign wvalid = (r_state == S_DATA);

    assign bready = (r_state == S_RESP);

endmodule

// File: tb/tb_cache_wb_buffer.sv
module tb_cache_wb_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         push;
    logic         push_ready;
    logic [31:0]  push_addr;
    logic [255:0] push_line;
    logic [31:0]  query_addr;
    logic         query_hit;
    logic         bus_err;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    cache_wb_buffer dut (
        .clk(clk), .rst(rst),
        .push(push), .push_ready(push_ready), .push_addr(push_addr), .push_line(push_line),
        .query_addr(query_addr), .query_hit(query_hit), .bus_err(bus_err),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are read at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk(input logic [31:0] b, input logic [31:0] s);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = b + s * i;
        return l;
    endfunction

    // Handshake recorder and stall-stability monitor
    logic [31:0] aq[$];
    logic [32:0] wq[$];
    logic        stab_en = 1'b0;
    logic        p_aws = 1'b0, p_ws = 1'b0, p_wlast = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0;

    always @(negedge clk) begin
        if (stab_en && p_aws) chk("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
        if (stab_en && p_ws)  chk("w_stable", {wvalid, wlast, wdata}, {1'b1, p_wlast, p_wdata});
        p_aws    = awvalid && !awready;
        p_ws     = wvalid && !wready;
        p_awaddr = awaddr;
        p_wdata  = wdata;
        p_wlast  = wlast;
        if (awvalid && awready) aq.push_back(awaddr);
        if (wvalid && wready)   wq.push_back({wlast, wdata});
    end

    task automatic drain_wait(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            cyc();
            if (push_ready) done = 1'b1;
        end
        chk(tag, done, 1'b1);
    endtask

    initial begin
        logic done;
        rst = 1; push = 0; push_addr = '0; push_line = '0; query_addr = '0;
        awready = 0; wready = 0; bresp = 2'b00; bvalid = 0;
        cyc(); cyc();
        rst = 0;
        @(negedge clk);
        chk("rst_push_ready", push_ready, 1'b1);
        chk("rst_valids", {awvalid, wvalid, wlast, bready, bus_err, query_hit}, 6'b0);

        // Basic drain, all readies high
        cyc();
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
        push = 1; push_addr = 32'h1000_0014; push_line = mk(32'h1111_1111, 32'h1111_1111);
        @(negedge clk);
        chk("c0_push_ready", push_ready, 1'b1);
        cyc(); push = 0;
        @(negedge clk);
        chk("c1_awvalid", awvalid, 1'b1);
        chk("c1_awaddr", awaddr, 32'h1000_0000);
        chk("c1_awlen_size_burst", {awlen, awsize, awburst}, {8'd7, 3'd2, 2'd1});
        chk("c1_wvalid", wvalid, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            @(negedge clk);
            chk("beat_valid", {wvalid, wstrb, awvalid}, {1'b1, 4'hF, 1'b0});
            chk("beat_data", wdata, 32'h1111_1111 * (k + 1));
            chk("beat_last", wlast, 1'(k == 7));
        end
        cyc();
        @(negedge clk);
        chk("c10_bready", {bready, push_ready, wvalid}, 3'b100);
        cyc();
        @(negedge clk);
        chk("c11_push_ready", {push_ready, bready}, 2'b10);

        // Query and push-while-busy
        cyc();
        aq.delete(); wq.delete();
        bvalid = 0;
        push = 1; push_addr = 32'h2000_0040; push_line = mk(32'hC0DE_0000, 1);
        query_addr = 32'h2000_0040;
        @(negedge clk);
        chk("q_c0_nohit", query_hit, 1'b0);
        cyc(); push = 0;
        @(negedge clk);
        chk("q_c1_hit", query_hit, 1'b1);
        query_addr = 32'h2000_005C; #1;
        chk("q_hit_5c", query_hit, 1'b1);
        query_addr = 32'h2000_0060; #1;
        chk("q_miss_60", query_hit, 1'b0);
        cyc();
        cyc();
        push = 1; push_addr = 32'h3000_0000; push_line = mk(32'hBAD0_0000, 1);
        @(negedge clk);
        chk("busy_push_ready", push_ready, 1'b0);
        cyc(); push = 0;
        repeat (6) cyc();
        query_addr = 32'h2000_0040;
        @(negedge clk);
        chk("q_resp_bready", {bready, query_hit}, 2'b11);
        cyc(); bvalid = 1;
        @(negedge clk);
        chk("q_resp_ok", {bus_err, bready}, 2'b01);
        cyc();
        @(negedge clk);
        chk("q_done", {push_ready, query_hit}, 2'b10);
        cyc();
        chk("busy_aw_count", aq.size(), 1);
        chk("busy_awaddr", aq[0], 32'h2000_0040);
        chk("busy_w_count", wq.size(), 8);
        for (int k = 0; k < 8; k++)
            chk("busy_beat", wq[k], {1'(k == 7), 32'hC0DE_0000 + k});

        // Error response
        aq.delete(); wq.delete();
        bresp = 2'b10; bvalid = 1;
        push = 1; push_addr = 32'h4000_0000; push_line = mk(32'h4040_0000, 1);
        cyc(); push = 0;
        repeat (9) cyc();
        @(negedge clk);
        chk("err_pulse", {bready, bus_err}, 2'b11);
        cyc();
        @(negedge clk);
        chk("err_one_cycle", {bus_err, push_ready, awvalid}, 3'b010);
        cyc();
        aq.delete(); wq.delete();
        bresp = 2'b00;
        push = 1; push_addr = 32'h4000_0100; push_line = mk(32'h5050_0000, 1);
        cyc(); push = 0;
        @(negedge clk);
        chk("err_next_aw", {awvalid, awaddr}, {1'b1, 32'h4000_0100});
        drain_wait("err_next_timeout");
        chk("err_next_wcount", wq.size(), 8);
        chk("err_next_beat0", wq[0], {1'b0, 32'h5050_0000});
        chk("err_next_beat7", wq[7], {1'b1, 32'h5050_0007});

        // Backpressure: awready low 3 cycles, wready 1,0,0 repeating
        aq.delete(); wq.delete();
        stab_en = 1; awready = 0; wready = 0; bvalid = 1; bresp = 2'b00;
        push = 1; push_addr = 32'h5000_0000; push_line = mk(32'hA0A0_0000, 32'h101);
        cyc(); push = 0;
        @(negedge clk);
        chk("bp_c1", {awvalid, wvalid}, 2'b10);
        cyc(); cyc();
        @(negedge clk);
        chk("bp_c3_no_w", {awvalid, wvalid}, 2'b10);
        cyc(); awready = 1;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            cyc();
            awready = 0;
            wready  = (k % 3 == 0);
            if (push_ready) done = 1'b1;
        end
        stab_en = 0;
        chk("bp_timeout", done, 1'b1);
        chk("bp_aw_count", aq.size(), 1);
        chk("bp_awaddr", aq[0], 32'h5000_0000);
        chk("bp_w_count", wq.size(), 8);
        for (int k = 0; k < 8; k++)
            chk("bp_beat", wq[k], {1'(k == 7), 32'hA0A0_0000 + 32'h101 * k});

        // Reset mid-burst
        awready = 1; wready = 1; bvalid = 0;
        push = 1; push_addr = 32'h6000_0000; push_line = mk(32'h6060_0000, 1);
        query_addr = 32'h6000_0000;
        cyc(); push = 0;
        repeat (4) cyc();
        rst = 1;
        @(negedge clk);
        chk("rm_beat4", wdata, 32'h6060_0003);
        cyc(); rst = 0;
        @(negedge clk);
        chk("rm_after_rst", {awvalid, wvalid, wlast, bready, push_ready, query_hit}, 6'b000010);
        cyc();
        bvalid = 1;
        push = 1; push_addr = 32'h7000_0000; push_line = mk(32'h7070_0000, 1);
        cyc(); push = 0;
        @(negedge clk);
        chk("rm_new_aw", {awvalid, awaddr}, {1'b1, 32'h7000_0000});
        cyc();
        @(negedge clk);
        chk("rm_new_beat0", {wvalid, wdata}, {1'b1, 32'h7070_0000});
        drain_wait("rm_drain_timeout");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_wb_buffer.md
# cache_wb_buffer

Single-entry victim/writeback buffer for the cache data path. Captures a full dirty line (LINE_WORDS × DATA_WIDTH bits) read from a cache data bank's all-words output, frees the bank immediately, and drains the line to memory as one AXI4 INCR write burst. It also provides a line-address match so the cache can stall a refill of a line still in flight to memory.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per word and per AXI beat
- LINE_WORDS, 8, words per line; power of two, 2..16
- ADDR_WIDTH, 32, byte address width

Ports (single clock; synchronous active-high reset):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- push  in  1  request to load a victim line
- push_ready  out  1  buffer empty and in IDLE; push is accepted only when push && push_ready
- push_addr  in  ADDR_WIDTH  victim line byte address; line-offset bits are ignored
- push_line  in  DATA_WIDTH*LINE_WORDS  line data; word 0 (lowest address) in bits [DATA_WIDTH-1:0]
- query_addr  in  ADDR_WIDTH  address to check against the buffered line
- query_hit  out  1  buffered line is pending and matches query_addr at line granularity
- bus_err  out  1  one-cycle pulse when the write response is not OKAY
- awaddr  out  ADDR_WIDTH; awlen  out  8; awsize  out  3; awburst  out  2; awvalid  out  1; awready  in  1
- wdata  out  DATA_WIDTH; wstrb  out  DATA_WIDTH/8; wlast  out  1; wvalid  out  1; wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: push_ready=1. On push: register line address (offset bits cleared), register push_line, clear beat counter, go to ADDR.
- ADDR: awvalid=1, awaddr=registered line address, awlen=LINE_WORDS-1, awsize=log2(DATA_WIDTH/8), awburst=2'b01 (INCR). On awready, go to DATA. All AW outputs hold stable while awvalid && !awready.
- DATA: wvalid=1, wdata=word[cnt], wstrb all ones, wlast=(cnt==LINE_WORDS-1). On wready: if wlast, go to RESP; otherwise cnt++. wdata/wlast hold stable while stalled.
- RESP: bready=1. On bvalid: go to IDLE; if bresp!=2'b00, bus_err=1 for that cycle only. The line is dropped either way; there is no retry.
- query_hit = (state!=IDLE) && query_addr[ADDR_WIDTH-1:log2(LINE_WORDS*DATA_WIDTH/8)] equals the stored tag. It is combinational on query_addr and registered state only. A line pushed in cycle N is visible to query from cycle N+1.
- AW and W are strictly sequential: no W beat before the AW handshake.
- Reset: state=IDLE, cnt=0, and awvalid, wvalid, wlast, bready, bus_err, query_hit are all 0; push_ready=1 from the cycle after rst. Reset mid-burst abandons the transaction. This is legal only alongside a system-wide reset.

## Timing
- Push in cycle 0: awvalid rises in cycle 1.
- AW handshake in cycle n: first W beat is valid in cycle n+1.
- Beat k is presented one cycle after handshake of beat k-1.
- After the wlast handshake, bready is 1 in the next cycle.
- bvalid handshake in cycle m: push_ready=1 in cycle m+1.
- Best case with all readies and bvalid high: push c0, AW c1, W c2..c(LINE_WORDS+1), B c(LINE_WORDS+2), push_ready again at c(LINE_WORDS+3). For the default, push_ready returns at c11.
- push while push_ready=0 is ignored. push_ready does not depend combinationally on push.

## Test plan
- Basic drain: push addr 0x1000_0014, line words 0x11111111..0x88888888, all readies held at 1 -> awaddr 0x1000_0000, awlen 7, awsize 2, awburst 1. Beats in order 0x11111111..0x88888888, wlast only on beat 8. push_ready returns at c11.
- Backpressure: awready low for 3 cycles; wready toggles 1,0,0,1,… -> AW/W outputs stable during every stall, no beat lost or duplicated, exactly 8 handshakes.
- Query: after pushing 0x2000_0040, query 0x2000_005C -> hit=1; query 0x2000_0060 -> hit=0. After B completes -> hit=0 for 0x2000_0040.
- Push while busy: assert push during DATA with a different line -> ignored; the original line completes unchanged.
- Error response: bresp=2'b10 -> bus_err exactly one cycle, state returns to IDLE, next push proceeds normally.
- Reset mid-burst: rst during beat 4 -> the next cycle has all valids 0 and push_ready=1. A new push then starts with beat 0.
